sipo_deserializer: RTL and testbench

SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

---
 rtl/sipo_deserializer.sv | 88 ++++++++
 tb/tb_sipo_deserializer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer with start-bit framing, selectable bit
// order, a single-entry output register with valid/ready, and error flags.
module sipo_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin_valid,
  input  logic             sin_data,
  input  logic             sin_start,
  input  logic             msb_first,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  input  logic             err_clr
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic             msb_lat;
  logic             start_acc, bit_acc, last_acc, can_xfer;

  assign start_acc = sin_valid && sin_start;
  assign bit_acc   = sin_valid && !sin_start && (state == RECV);
  assign last_acc  = bit_acc && (cnt == CW'(WIDTH - 1));
  // Output register is free if empty or being drained this very cycle.
  assign can_xfer  = !out_valid || out_ready;
  assign busy      = (state == RECV);

  assign shreg_nxt = msb_lat ? {shreg[WIDTH-2:0], sin_data}
                             : {sin_data, shreg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start_acc)     state_nxt = RECV;
    else if (last_acc) state_nxt = IDLE;
  end

  // Bit 0 is placed at the far end so the remaining shifts walk it home.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      cnt     <= '0;
      msb_lat <= 1'b0;
    end else if (start_acc) begin
      shreg   <= msb_first ? {{(WIDTH-1){1'b0}}, sin_data}
                           : {sin_data, {(WIDTH-1){1'b0}}};
      cnt     <= CW'(1);
      msb_lat <= msb_first;
    end else if (bit_acc) begin
      shreg <= shreg_nxt;
      cnt   <= last_acc ? '0 : cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (last_acc && can_xfer) begin
        out_valid <= 1'b1;
        out_data  <= shreg_nxt;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // A new drop wins over a simultaneous clear.
      overrun   <= (last_acc && !can_xfer) || (overrun && !err_clr);
      frame_err <= start_acc && (state == RECV);
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer (WIDTH=8): table-driven frames plus directed
// gap, overrun, abort and reset sequences, checked through a word scoreboard.
module tb_sipo_deserializer;
  localparam int W = 8;

  logic         clk = 0, rst_n = 0;
  logic         sin_valid = 0, sin_data = 0, sin_start = 0, msb_first = 1;
  logic         out_ready = 1, err_clr = 0;
  logic         out_valid, busy, overrun, frame_err;
  logic [W-1:0] out_data;

  int checks = 0, failures = 0, fe_cnt = 0;
  logic [W-1:0] sb_q[$];

  sipo_deserializer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .sin_valid(sin_valid), .sin_data(sin_data),
    .sin_start(sin_start), .msb_first(msb_first), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .busy(busy),
    .overrun(overrun), .frame_err(frame_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && frame_err) fe_cnt++;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=%0h required=none", out_data);
      end else begin
        chk("word", {24'h0, out_data}, {24'h0, sb_q.pop_front()});
      end
    end
  end

  task automatic send_bit(input logic d, input logic st);
    sin_valid = 1; sin_data = d; sin_start = st;
    @(posedge clk); #1;
    sin_valid = 0; sin_start = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // seq[W-1] is sent first; gap_at < 0 means no gap.
  task automatic send_frame(input logic msb, input logic [W-1:0] seq,
                            input logic tog, input int gap_at, input int gap_len);
    msb_first = msb;
    for (int i = 0; i < W; i++) begin
      send_bit(seq[W-1-i], i == 0);
      if (i == 0) begin
        chk("busy_after_start", {31'h0, busy}, 32'h1);
        if (tog) msb_first = ~msb;
      end
      if (i == gap_at) idle(gap_len);
    end
    chk("busy_after_last", {31'h0, busy}, 32'h0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 50) begin idle(1); n++; end
    chk("drain_left", sb_q.size(), 0);
  endtask

  typedef struct {
    logic         msb;
    logic [W-1:0] seq;
    logic         tog;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{1'b1, 8'hA6, 1'b0, 8'hA6};
    vecs[1] = '{1'b0, 8'hA6, 1'b0, 8'h65};
    vecs[2] = '{1'b0, 8'hA6, 1'b1, 8'h65};
    vecs[3] = '{1'b0, 8'h01, 1'b0, 8'h80};
    vecs[4] = '{1'b1, 8'h3C, 1'b1, 8'h3C};

    #1;
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_data", {24'h0, out_data}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_ovr_ferr", {30'h0, overrun, frame_err}, 32'h0);
    idle(2);
    rst_n = 1;
    idle(1);

    // Valid bits without a start are ignored in IDLE.
    send_bit(1, 0); send_bit(1, 0);
    chk("idle_ignore_busy", {31'h0, busy}, 32'h0);
    idle(3);
    chk("idle_ignore_valid", {31'h0, out_valid}, 32'h0);

    foreach (vecs[k]) begin
      sb_q.push_back(vecs[k].exp);
      send_frame(vecs[k].msb, vecs[k].seq, vecs[k].tog, -1, 0);
      drain();
    end

    // Gaps in sin_valid do not advance the bit count.
    sb_q.push_back(8'hF0);
    send_frame(1, 8'hF0, 0, 3, 3);
    drain();

    // Back-to-back frames with ready low: the second word is dropped.
    out_ready = 0;
    sb_q.push_back(8'h3C);
    send_frame(1, 8'h3C, 0, -1, 0);
    send_frame(1, 8'hC3, 0, -1, 0);
    idle(2);
    chk("ovr_data_held", {24'h0, out_data}, 32'h3C);
    chk("ovr_valid", {31'h0, out_valid}, 32'h1);
    chk("ovr_set", {31'h0, overrun}, 32'h1);
    err_clr = 1; idle(1); err_clr = 0;
    chk("ovr_cleared", {31'h0, overrun}, 32'h0);
    out_ready = 1;
    drain();

    // Same pair with ready high: both words delivered, no overrun.
    sb_q.push_back(8'h3C); sb_q.push_back(8'hC3);
    send_frame(1, 8'h3C, 0, -1, 0);
    send_frame(1, 8'hC3, 0, -1, 0);
    drain();
    chk("b2b_no_ovr", {31'h0, overrun}, 32'h0);

    // Abort after 5 bits: one frame_err pulse, only the restarted word out.
    chk("ferr_none_before", fe_cnt, 0);
    msb_first = 1;
    send_bit(1, 1);
    for (int i = 0; i < 4; i++) send_bit(1, 0);
    sb_q.push_back(8'h81);
    send_frame(1, 8'h81, 0, -1, 0);
    drain();
    idle(2);
    chk("ferr_pulses", fe_cnt, 1);

    // Asynchronous reset mid-frame.
    send_bit(1, 1); send_bit(0, 0); send_bit(1, 0); send_bit(1, 0);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_valid_data", {23'h0, out_valid, out_data}, 32'h0);
    chk("arst_ovr_ferr", {30'h0, overrun, frame_err}, 32'h0);
    idle(2);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    send_bit(1, 0); send_bit(0, 0); send_bit(1, 0); send_bit(1, 0);
    chk("post_rst_needs_start", {31'h0, busy}, 32'h0);
    sb_q.push_back(8'h5A);
    send_frame(1, 8'h5A, 0, -1, 0);
    drain();
    idle(12);
    chk("final_ferr", fe_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
